// File: rtl/emu_dt_arbiter_if.sv
// Timestep handshake bundle between emulated models (master) and the dt arbiter (slave).
interface emu_dt_arbiter_if #(
  parameter int unsigned N_REQ    = 4,
  parameter int unsigned DT_WIDTH = 27
);
  logic [N_REQ*DT_WIDTH-1:0] dt_req;
  logic [DT_WIDTH-1:0]       emu_dt;
  logic                      emu_stall;
  logic [N_REQ-1:0]          req_hit;

  modport master (output dt_req, input emu_dt, emu_stall, req_hit);
  modport slave  (input dt_req, output emu_dt, emu_stall, req_hit);
endinterface

// File: rtl/emu_dt_arbiter.sv
// Grants the minimum valid timestep, accumulates emulated time and sequences run/pause/step-N.
// Optional stop-at-target-time clamp is enabled by defining EMU_TIME_STOP_EN.
module emu_dt_arbiter #(
  parameter int unsigned          N_REQ      = 4,
  parameter int unsigned          DT_WIDTH   = 27,
  parameter int unsigned          TIME_WIDTH = 40,
  parameter int unsigned          STEP_WIDTH = 16,
  parameter logic [DT_WIDTH-1:0]  DT_MAX     = {1'b0, {(DT_WIDTH-1){1'b1}}}
) (
  input  logic                  emu_clk,
  input  logic                  emu_rst_n,
  emu_dt_arbiter_if.slave       dt,
  input  logic                  ctrl_run,
  input  logic                  step_cmd,
  input  logic [STEP_WIDTH-1:0] step_count,
  output logic [TIME_WIDTH-1:0] emu_time,
  output logic                  step_busy
`ifdef EMU_TIME_STOP_EN
  ,
  input  logic [TIME_WIDTH-1:0] stop_time,
  output logic                  stopped
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, STEP} state_t;

  state_t                  state;
  logic [STEP_WIDTH-1:0]   step_cnt;
  logic [DT_WIDTH-1:0]     req_w [N_REQ];
  logic [N_REQ-1:0]        valid;
  logic [DT_WIDTH-1:0]     dt_min;
  logic [DT_WIDTH-1:0]     grant;
  logic [N_REQ-1:0]        hit;
  logic                    advancing;
  logic [TIME_WIDTH-1:0]   time_next;
  logic                    step_start;
  logic                    refuse;
  logic                    stop_hit;

  // Minimum positive request; starting from DT_MAX folds in the clamp and the no-valid case.
  always_comb begin
    dt_min = DT_MAX;
    for (int i = 0; i < int'(N_REQ); i++) begin
      req_w[i] = dt.dt_req[i*DT_WIDTH +: DT_WIDTH];
      valid[i] = !req_w[i][DT_WIDTH-1] && (req_w[i] != '0);
      if (valid[i] && (req_w[i] < dt_min)) dt_min = req_w[i];
    end
  end

`ifdef EMU_TIME_STOP_EN
  localparam int unsigned CMP_WIDTH = (TIME_WIDTH > DT_WIDTH) ? TIME_WIDTH : DT_WIDTH;
  logic [TIME_WIDTH-1:0] remaining;

  // Shorten the last step so emulated time lands exactly on stop_time.
  always_comb begin
    remaining = stop_time - emu_time;
    grant     = (CMP_WIDTH'(remaining) < CMP_WIDTH'(dt_min)) ? DT_WIDTH'(remaining) : dt_min;
    refuse    = (remaining == '0);
    stop_hit  = (time_next == stop_time);
  end
`else
  assign grant    = dt_min;
  assign refuse   = 1'b0;
  assign stop_hit = 1'b0;
`endif

  always_comb begin
    hit = '0;
    for (int i = 0; i < int'(N_REQ); i++) hit[i] = valid[i] && (req_w[i] == grant);
  end

  assign advancing    = (state != IDLE);
  assign time_next    = emu_time + TIME_WIDTH'(grant);
  assign step_start   = step_cmd && (step_count != '0);
  assign dt.emu_dt    = advancing ? grant : '0;
  assign dt.req_hit   = advancing ? hit : '0;
  assign dt.emu_stall = !advancing;
  assign step_busy    = (state == STEP);

  // Control FSM and time accumulator.
  always_ff @(posedge emu_clk or negedge emu_rst_n) begin
    if (!emu_rst_n) begin
      state    <= IDLE;
      emu_time <= '0;
      step_cnt <= '0;
    end else begin
      if (advancing) emu_time <= time_next;
      case (state)
        IDLE: begin
          if (step_start) begin
            if (!refuse) begin
              state    <= STEP;
              step_cnt <= step_count;
            end
          end else if (ctrl_run && !refuse) begin
            state <= RUN;
          end
        end
        RUN: begin
          if (!ctrl_run || stop_hit) state <= IDLE;
        end
        STEP: begin
          step_cnt <= step_cnt - STEP_WIDTH'(1);
          if ((step_cnt == STEP_WIDTH'(1)) || stop_hit) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef EMU_TIME_STOP_EN
  // Sticky stop flag: set on reaching or refusing at the target, cleared by an accepted start.
  always_ff @(posedge emu_clk or negedge emu_rst_n) begin
    if (!emu_rst_n) begin
      stopped <= 1'b0;
    end else if ((state == IDLE) && (step_start || ctrl_run)) begin
      stopped <= refuse;
    end else if (advancing && stop_hit) begin
      stopped <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_emu_dt_arbiter.sv
// Self-checking bench for emu_dt_arbiter: directed scenarios plus randomized traffic
// compared against a behavioural model of the grant/time/step rules.
module tb_emu_dt_arbiter;
  localparam int unsigned N  = 4;
  localparam int unsigned W  = 27;
  localparam int unsigned TW = 40;
  localparam int unsigned SW = 16;
  localparam int DT_MAX_I = (1 << (W-1)) - 1;

  logic          emu_clk = 1'b0;
  logic          emu_rst_n;
  logic          ctrl_run, step_cmd;
  logic [SW-1:0] step_count;
  logic [TW-1:0] emu_time;
  logic          step_busy;
  logic          ctrl_run8;
  logic [SW-1:0] step_count8;
  logic [7:0]    emu_time8;
  logic          step_busy8;
  logic          step_cmd8;
`ifdef EMU_TIME_STOP_EN
  logic [TW-1:0] stop_time;
  logic          stopped;
  logic [7:0]    stop_time8;
  logic          stopped8;
`endif

  int errors = 0;
  int checks = 0;

  int            m_mode;   // 0 idle, 1 run, 2 step
  int            m_left;
  logic [TW-1:0] m_time;
  logic [TW-1:0] m_stop;
  bit            m_stopped;

  always #5 emu_clk = ~emu_clk;

  emu_dt_arbiter_if #(.N_REQ(N), .DT_WIDTH(W)) bus ();
  emu_dt_arbiter_if #(.N_REQ(N), .DT_WIDTH(W)) bus8 ();

  emu_dt_arbiter #(.N_REQ(N), .DT_WIDTH(W), .TIME_WIDTH(TW), .STEP_WIDTH(SW)) dut (
    .emu_clk(emu_clk), .emu_rst_n(emu_rst_n), .dt(bus),
    .ctrl_run(ctrl_run), .step_cmd(step_cmd), .step_count(step_count),
    .emu_time(emu_time), .step_busy(step_busy)
`ifdef EMU_TIME_STOP_EN
    , .stop_time(stop_time), .stopped(stopped)
`endif
  );

  emu_dt_arbiter #(.N_REQ(N), .DT_WIDTH(W), .TIME_WIDTH(8), .STEP_WIDTH(SW)) dut8 (
    .emu_clk(emu_clk), .emu_rst_n(emu_rst_n), .dt(bus8),
    .ctrl_run(ctrl_run8), .step_cmd(step_cmd8), .step_count(step_count8),
    .emu_time(emu_time8), .step_busy(step_busy8)
`ifdef EMU_TIME_STOP_EN
    , .stop_time(stop_time8), .stopped(stopped8)
`endif
  );

  function automatic logic [N*W-1:0] pack(input int a0, input int a1, input int a2, input int a3);
    int v [4];
    logic [N*W-1:0] p;
    v[0] = a0; v[1] = a1; v[2] = a2; v[3] = a3;
    for (int i = 0; i < 4; i++) p[i*W +: W] = W'(v[i]);
    return p;
  endfunction

  // Grant = smallest positive request (DT_MAX if none), optionally cut to the time left.
  function automatic void model_out(input logic [N*W-1:0] req, input logic [TW-1:0] t,
                                    input logic [TW-1:0] stp, output int g,
                                    output logic [N-1:0] h);
    int vals [$];
    logic signed [W-1:0] s;
    logic [TW-1:0] rem;
    for (int i = 0; i < int'(N); i++) begin
      s = req[i*W +: W];
      vals.push_back(int'(s));
    end
    g = DT_MAX_I;
    foreach (vals[i]) if (vals[i] > 0 && vals[i] < g) g = vals[i];
    rem = stp - t;
`ifdef EMU_TIME_STOP_EN
    if (rem < TW'(g)) g = int'(rem);
`endif
    h = '0;
    foreach (vals[i]) h[i] = (vals[i] > 0) && (vals[i] == g);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_left = 0; m_time = '0; m_stopped = 1'b0;
  endtask

  // Check this cycle's outputs against the model, then clock both forward.
  task automatic cyc();
    int g;
    logic [N-1:0] h;
    bit adv, start_step, start;
    #1;
    model_out(bus.dt_req, m_time, m_stop, g, h);
    adv = (m_mode != 0);
    chk("emu_stall", 64'(bus.emu_stall), 64'(!adv));
    chk("emu_dt", 64'(bus.emu_dt), adv ? 64'(g) : 64'd0);
    chk("req_hit", 64'(bus.req_hit), adv ? 64'(h) : 64'd0);
    chk("step_busy", 64'(step_busy), 64'(m_mode == 2));
    chk("emu_time", 64'(emu_time), 64'(m_time));
`ifdef EMU_TIME_STOP_EN
    chk("stopped", 64'(stopped), 64'(m_stopped));
`endif
    @(posedge emu_clk);
    if (adv) m_time = m_time + TW'(g);
    case (m_mode)
      0: begin
        start_step = step_cmd && (step_count != 0);
        start = start_step || ctrl_run;
`ifdef EMU_TIME_STOP_EN
        if (start) begin
          m_stopped = (m_stop == m_time);
          if (m_stopped) start = 1'b0;
        end
`endif
        if (start) begin
          m_mode = start_step ? 2 : 1;
          m_left = int'(step_count);
        end
      end
      1: if (!ctrl_run) m_mode = 0;
      default: begin
        m_left--;
        if (m_left == 0) m_mode = 0;
      end
    endcase
`ifdef EMU_TIME_STOP_EN
    if (adv && m_time == m_stop) begin
      m_mode = 0;
      m_stopped = 1'b1;
    end
`endif
    @(negedge emu_clk);
  endtask

  initial begin
    int cnt;
    logic [TW-1:0] t0;
    int r, v [4];

    emu_rst_n = 1'b0;
    ctrl_run = 1'b0; step_cmd = 1'b0; step_count = '0;
    ctrl_run8 = 1'b0; step_cmd8 = 1'b0; step_count8 = '0;
    bus.dt_req = pack(5, 6, 7, 8);
    bus8.dt_req = pack(100, 0, 0, 0);
    m_stop = '1;
`ifdef EMU_TIME_STOP_EN
    stop_time = '1;
    stop_time8 = '0;
`endif
    model_reset();
    @(negedge emu_clk);
    @(negedge emu_clk);
    #1;
    chk("rst_stall", 64'(bus.emu_stall), 64'd1);
    chk("rst_dt", 64'(bus.emu_dt), 64'd0);
    chk("rst_hit", 64'(bus.req_hit), 64'd0);
    chk("rst_busy", 64'(step_busy), 64'd0);
    chk("rst_time", 64'(emu_time), 64'd0);
    @(negedge emu_clk);
    emu_rst_n = 1'b1;

    // Free run, mixed valid/invalid requests.
    bus.dt_req = pack(100, 40, 0, -5);
    ctrl_run = 1'b1;
    cyc();
    #1;
    chk("run_dt", 64'(bus.emu_dt), 64'd40);
    chk("run_hit", 64'(bus.req_hit), 64'b0010);
    for (int i = 0; i < 3; i++) cyc();
    #1;
    chk("run_time120", 64'(emu_time), 64'd120);

    // Ties, then no valid request.
    bus.dt_req = pack(25, 25, 90, 25);
    cyc();
    #1;
    chk("tie_dt", 64'(bus.emu_dt), 64'd25);
    chk("tie_hit", 64'(bus.req_hit), 64'b1011);
    bus.dt_req = pack(0, -1, -100, 0);
    cyc();
    #1;
    chk("none_dt", 64'(bus.emu_dt), 64'(DT_MAX_I));
    chk("none_hit", 64'(bus.req_hit), 64'd0);

    // Step of 3.
    ctrl_run = 1'b0;
    bus.dt_req = pack(10, 20, 30, 40);
    cyc();
    t0 = emu_time;
    step_cmd = 1'b1; step_count = 16'd3;
    cyc();
    step_cmd = 1'b0;
    cnt = 0;
    #1 if (step_busy) cnt++;
    for (int i = 0; i < 5; i++) begin
      cyc();
      #1 if (step_busy) cnt++;
    end
    chk("step3_busy_cycles", 64'(cnt), 64'd3);
    chk("step3_time", 64'(emu_time - t0), 64'd30);
    chk("step3_stall", 64'(bus.emu_stall), 64'd1);

    // step_cmd beats ctrl_run, then RUN resumes; zero-count pulse is ignored.
    step_cmd = 1'b1; step_count = 16'd2; ctrl_run = 1'b1;
    cyc();
    step_cmd = 1'b0;
    for (int i = 0; i < 3; i++) cyc();
    #1;
    chk("prio_run_stall", 64'(bus.emu_stall), 64'd0);
    chk("prio_run_busy", 64'(step_busy), 64'd0);
    ctrl_run = 1'b0;
    cyc();
    step_cmd = 1'b1; step_count = '0;
    cyc();
    step_cmd = 1'b0;
    #1;
    chk("zero_step_stall", 64'(bus.emu_stall), 64'd1);
    chk("zero_step_busy", 64'(step_busy), 64'd0);

`ifndef EMU_TIME_STOP_EN
    // 8-bit time accumulator wraps silently.
    ctrl_run8 = 1'b1;
    cyc();
    cyc();
    #1 chk("wrap_t1", 64'(emu_time8), 64'd100);
    cyc();
    #1 chk("wrap_t2", 64'(emu_time8), 64'd200);
    cyc();
    #1 chk("wrap_t3", 64'(emu_time8), 64'd44);
    ctrl_run8 = 1'b0;
`endif

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 4; i++) begin
        r = int'($urandom_range(0, 9));
        if (r < 2)       v[i] = -int'($urandom_range(0, 100));
        else if (r == 2) v[i] = DT_MAX_I;
        else             v[i] = int'($urandom_range(1, 30));
      end
      bus.dt_req = pack(v[0], v[1], v[2], v[3]);
      if ($urandom_range(0, 9) == 0) ctrl_run = 1'($urandom_range(0, 1));
      step_cmd = ($urandom_range(0, 7) == 0);
      step_count = SW'($urandom_range(0, 4));
      cyc();
    end
    step_cmd = 1'b0;
    ctrl_run = 1'b0;
    cyc();

    // Reset in the middle of a step sequence.
    bus.dt_req = pack(7, 9, 11, 13);
    step_cmd = 1'b1; step_count = 16'd10;
    cyc();
    step_cmd = 1'b0;
    for (int i = 0; i < 5; i++) cyc();
    emu_rst_n = 1'b0;
    #1;
    chk("midrst_stall", 64'(bus.emu_stall), 64'd1);
    chk("midrst_dt", 64'(bus.emu_dt), 64'd0);
    chk("midrst_time", 64'(emu_time), 64'd0);
    chk("midrst_busy", 64'(step_busy), 64'd0);
    model_reset();
    @(negedge emu_clk);
    emu_rst_n = 1'b1;
    cyc();
    chk("post_rst_busy", 64'(step_busy), 64'd0);

`ifdef EMU_TIME_STOP_EN
    // Stop at target time; held ctrl_run is then refused.
    stop_time = 40'd95; m_stop = 40'd95;
    bus.dt_req = pack(40, 40, 40, 40);
    ctrl_run = 1'b1;
    for (int i = 0; i < 4; i++) cyc();
    #1;
    chk("stop_time95", 64'(emu_time), 64'd95);
    chk("stop_flag", 64'(stopped), 64'd1);
    chk("stop_stall", 64'(bus.emu_stall), 64'd1);
    cyc();
    cyc();
    #1;
    chk("stop_refuse_stall", 64'(bus.emu_stall), 64'd1);
    chk("stop_refuse_flag", 64'(stopped), 64'd1);
    ctrl_run = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/emu_dt_arbiter.md
Name: emu_dt_arbiter

Overview:
- Timestep manager at the far end of the dt_req/emu_dt handshake used by every emulated analog or clock model.
- Collects signed timestep requests from N_REQ models and broadcasts the granted step (the minimum valid request, clamped) as emu_dt.
- Flags which requesters were hit and accumulates emulated time.
- Provides run/pause/step-N control for the emulator host through a small FSM.

Parameters:
N_REQ, 4, number of requesting models
DT_WIDTH, 27, width of each signed timestep word (matches the DT format width)
TIME_WIDTH, 40, width of the unsigned emulated-time accumulator
STEP_WIDTH, 16, width of the step-count command
DT_MAX, 2**(DT_WIDTH-1)-1, upper clamp on the granted timestep

Ports:
emu_clk  in  1  emulator clock
emu_rst_n  in  1  asynchronous, active-low reset
dt_req  in  N_REQ*DT_WIDTH  packed signed requests; requester i occupies bits [i*DT_WIDTH +: DT_WIDTH]
ctrl_run  in  1  level; free-run request
step_cmd  in  1  single-cycle pulse; run step_count steps
step_count  in  STEP_WIDTH  number of steps for step_cmd
emu_dt  out  DT_WIDTH  granted signed timestep; 0 when stalled
emu_stall  out  1  1 = time frozen this cycle
req_hit  out  N_REQ  bit i = requester i's request equals the granted dt
emu_time  out  TIME_WIDTH  accumulated emulated time (registered)
step_busy  out  1  1 while in STEP

Behaviour:
- Reset (async on emu_rst_n=0): state=IDLE, emu_time=0, step counter=0. Outputs: emu_stall=1, emu_dt=0, req_hit=0, step_busy=0.
- Request validity: a request ≤0 is invalid and ignored.
- dt_min = minimum of valid requests; DT_MAX if none are valid; then clamped to DT_MAX.
- Combinational in state: emu_dt, req_hit and emu_stall are same-cycle functions of dt_req and the registered state. Zero latency from dt_req to emu_dt is required so models see a consistent step.
- Advancing cycle (state RUN or STEP):
  - emu_stall=0, emu_dt=dt_min.
  - req_hit[i]=1 iff request i is valid and equals dt_min. All tied requesters are hit.
  - If no request is valid, req_hit=0.
- IDLE: emu_stall=1, emu_dt=0, req_hit=0.
- emu_time update: on each advancing edge, emu_time <= emu_time + zero-extended emu_dt, modulo 2^TIME_WIDTH. Wrap is silent.
- FSM:
  - IDLE -> STEP when step_cmd=1 and step_count≠0; counter <= step_count. step_cmd has priority over ctrl_run.
  - IDLE, step_cmd=1 with step_count=0: ignored, stay IDLE.
  - IDLE -> RUN when ctrl_run=1 (and no valid step_cmd).
  - RUN -> IDLE when ctrl_run=0. step_cmd is ignored in RUN.
  - STEP: counter decrements on each advancing edge; when the counter equals 1 on an advancing edge, next state is IDLE. ctrl_run and step_cmd are ignored.
  - step_busy=1 exactly in STEP.
- STEP of N therefore produces exactly N advancing cycles; the first advancing cycle is the cycle after step_cmd.
- Reset mid-RUN or mid-STEP: immediate return to reset values; the step count is lost.

Optional Feature:
- Macro: EMU_TIME_STOP_EN.
- When defined, add ports:
  - stop_time  in  TIME_WIDTH  target emulated time
  - stopped  out  1  sticky flag
- Clamp while advancing:
  - remaining = stop_time - emu_time (TIME_WIDTH, unsigned).
  - If remaining < dt_min, emu_dt = remaining and req_hit bits are set only for valid requests equal to remaining.
- Stop: when the post-advance emu_time equals stop_time, next state = IDLE and stopped <= 1. This applies in both RUN and STEP.
- Refused start: IDLE with remaining=0 refuses both RUN and STEP (stays IDLE, stopped=1).
- stopped clears on the edge that accepts a ctrl_run or step_cmd transition. Reset value is 0.
- When the macro is not defined: the ports are absent and there is no clamp or stop.

Test Plan:
- Reset, then ctrl_run=1, dt_req={100,40,0,-5} -> first advancing cycle emu_dt=40, req_hit=4'b0010; emu_time=40,80,120 on successive edges.
- Ties: dt_req={25,25,90,25}, RUN -> emu_dt=25, req_hit=4'b1011. All requests ≤0 -> emu_dt=DT_MAX, req_hit=0.
- step_cmd with step_count=3, dt_min=10, ctrl_run=0 -> exactly 3 advancing cycles, step_busy high 3 cycles, emu_time 0→30, then IDLE with emu_stall=1.
- Simultaneous step_cmd (step_count=2) and ctrl_run=1 in IDLE -> STEP taken, 2 steps, then RUN. step_count=0 pulse -> no state change.
- emu_time preloaded near wrap by running with TIME_WIDTH=8, dt_req=100 -> sequence 100,200,44 (wrap mod 256).
- EMU_TIME_STOP_EN, stop_time=95, dt_req=40, RUN -> emu_dt 40,40,15; emu_time=95; stopped=1; IDLE. Then ctrl_run held -> remains IDLE, stopped=1.
- Assert emu_rst_n low mid-STEP (counter=5) -> emu_stall=1, emu_dt=0, emu_time=0 immediately; step_busy=0.
